// File: rtl/microwave_ctrl_pkg.sv
// Shared definitions for the microwave oven sequencer: FSM state codes,
// BCD digit limits and a small digit-validity helper.
package microwave_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] BCD_MAX_UNIT     = 4'd9;
  localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

  // A keypad code is a usable digit only in the range 0..9.
  function automatic logic is_digit(input logic [3:0] d);
    return (d <= BCD_MAX_UNIT);
  endfunction

endpackage

// File: rtl/microwave_ctrl_bcd_countdown.sv
// Combinational one-second BCD decrement of an MM:SS cook time.
// Works digit by digit with borrows; 0000 is held and never wraps to 9959.
// Seconds tens above 5 (e.g. 0090) simply count down as entered.
module bcd_countdown
  import microwave_ctrl_pkg::*;
(
  input  logic [7:0] mins,
  input  logic [7:0] secs,
  output logic [7:0] dec_mins,
  output logic [7:0] dec_secs,
  output logic       dec_zero
);

  // Borrow chain: secs units -> secs tens -> mins units -> mins tens.
  always_comb begin
    dec_mins = mins;
    dec_secs = secs;
    if ({mins, secs} != 16'h0000) begin
      if (secs[3:0] != 4'd0) begin
        dec_secs[3:0] = secs[3:0] - 4'd1;
      end else begin
        dec_secs[3:0] = BCD_MAX_UNIT;
        if (secs[7:4] != 4'd0) begin
          dec_secs[7:4] = secs[7:4] - 4'd1;
        end else begin
          dec_secs[7:4] = BCD_MAX_SEC_TENS;
          if (mins[3:0] != 4'd0) begin
            dec_mins[3:0] = mins[3:0] - 4'd1;
          end else begin
            dec_mins[3:0] = BCD_MAX_UNIT;
            dec_mins[7:4] = mins[7:4] - 4'd1;
          end
        end
      end
    end
  end

  assign dec_zero = ({dec_mins, dec_secs} == 16'h0000);

endmodule

// File: rtl/microwave_ctrl.sv
// Top-level microwave oven sequencer: assembles keypad digits into an MM:SS
// cook time, runs the start/stop/cancel/door FSM, counts down on the 1 Hz
// strobe and drives the magnetron, the end-of-cook alarm and the encoder enable.
module microwave_ctrl
  import microwave_ctrl_pkg::*;
#(
  parameter int ALARM_TICKS      = 5,
  parameter bit TICK_EN_IN_PAUSE = 1'b0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] D,
  input  logic       loadn,
  output logic       enbn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       canceln,
  input  logic       door_closed,
  input  logic       tick_1hz,
  output logic [7:0] mins,
  output logic [7:0] secs,
  output logic       magnetron,
  output logic       alarm,
  output logic [2:0] state
);

  // The alarm leaves DONE on the tick that finds the counter at this value.
  localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

  state_t     state_q, state_d;
  logic [7:0] mins_d, secs_d;
  logic [7:0] alarm_cnt_q, alarm_cnt_d;
  logic       loadn_q, startn_q, stopn_q, canceln_q;
  logic       key_ev, start_ev, stop_ev, cancel_ev;
  logic [7:0] dec_mins, dec_secs;
  logic       dec_zero;
  logic       time_zero;

  bcd_countdown u_countdown (
    .mins     (mins),
    .secs     (secs),
    .dec_mins (dec_mins),
    .dec_secs (dec_secs),
    .dec_zero (dec_zero)
  );

  // A held button is one event: only a high-to-low transition counts.
  assign key_ev    = loadn_q   & ~loadn;
  assign start_ev  = startn_q  & ~startn;
  assign stop_ev   = stopn_q   & ~stopn;
  assign cancel_ev = canceln_q & ~canceln;
  assign time_zero = ({mins, secs} == 16'h0000);
  assign state     = state_q;

  // Previous button levels for falling-edge detection; released after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      loadn_q   <= 1'b1;
      startn_q  <= 1'b1;
      stopn_q   <= 1'b1;
      canceln_q <= 1'b1;
    end else begin
      loadn_q   <= loadn;
      startn_q  <= startn;
      stopn_q   <= stopn;
      canceln_q <= canceln;
    end
  end

  // State, time, alarm counter and registered outputs derived from next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      mins        <= 8'h00;
      secs        <= 8'h00;
      alarm_cnt_q <= 8'd0;
      magnetron   <= 1'b0;
      alarm       <= 1'b0;
      enbn        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mins        <= mins_d;
      secs        <= secs_d;
      alarm_cnt_q <= alarm_cnt_d;
      magnetron   <= (state_d == COOK);
      alarm       <= (state_d == DONE);
      enbn        <= (state_d == COOK) || (state_d == PAUSE) || (state_d == DONE);
    end
  end

  // Next-state logic; events are resolved cancel > stop > door open > start > key.
  always_comb begin
    state_d     = state_q;
    mins_d      = mins;
    secs_d      = secs;
    alarm_cnt_d = alarm_cnt_q;
    case (state_q)
      IDLE: begin
        if (cancel_ev || stop_ev || start_ev) begin
          mins_d = 8'h00;
          secs_d = 8'h00;
        end else if (key_ev && is_digit(D)) begin
          {mins_d, secs_d} = {mins[3:0], secs, D};
          state_d          = ENTRY;
        end
      end
      ENTRY: begin
        if (cancel_ev) begin
          mins_d  = 8'h00;
          secs_d  = 8'h00;
          state_d = IDLE;
        end else if (stop_ev) begin
          state_d = ENTRY;
        end else if (start_ev) begin
          if (door_closed && !time_zero) state_d = COOK;
        end else if (key_ev && is_digit(D)) begin
          {mins_d, secs_d} = {mins[3:0], secs, D};
        end
      end
      COOK: begin
        if (cancel_ev) begin
          mins_d  = 8'h00;
          secs_d  = 8'h00;
          state_d = IDLE;
        end else if (stop_ev || !door_closed) begin
          state_d = PAUSE;
        end else if (tick_1hz) begin
          mins_d = dec_mins;
          secs_d = dec_secs;
          if (dec_zero) state_d = DONE;
        end
      end
      PAUSE: begin
        if (cancel_ev || stop_ev) begin
          mins_d  = 8'h00;
          secs_d  = 8'h00;
          state_d = IDLE;
        end else if (start_ev && door_closed) begin
          state_d = COOK;
        end else if (TICK_EN_IN_PAUSE && tick_1hz && !dec_zero) begin
          mins_d = dec_mins;
          secs_d = dec_secs;
        end
      end
      DONE: begin
        if (cancel_ev || stop_ev || start_ev || key_ev || !door_closed) begin
          alarm_cnt_d = 8'd0;
          state_d     = IDLE;
        end else if (tick_1hz) begin
          if (alarm_cnt_q == ALARM_LAST) begin
            alarm_cnt_d = 8'd0;
            state_d     = IDLE;
          end else begin
            alarm_cnt_d = alarm_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        mins_d      = 8'h00;
        secs_d      = 8'h00;
        alarm_cnt_d = 8'd0;
        state_d     = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_microwave_ctrl.sv
// Self-checking bench for microwave_ctrl: a table of one-cycle actions with
// hand-computed expected state and time, plus hand-written sequences for a
// held key and an asynchronous reset in the middle of cooking.
module tb_microwave_ctrl;
  import microwave_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] D;
  logic       loadn, startn, stopn, canceln, door_closed, tick_1hz;
  logic       enbn, magnetron, alarm;
  logic [7:0] mins, secs;
  logic [2:0] state;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    bit         key;
    logic [3:0] d;
    bit         start;
    bit         stop;
    bit         cancel;
    bit         tick;
    bit         door;
    state_t     es;
    logic [7:0] em;
    logic [7:0] esec;
  } vec_t;

  vec_t vecs[$];

  microwave_ctrl #(.ALARM_TICKS(5), .TICK_EN_IN_PAUSE(1'b0)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .D           (D),
    .loadn       (loadn),
    .enbn        (enbn),
    .startn      (startn),
    .stopn       (stopn),
    .canceln     (canceln),
    .door_closed (door_closed),
    .tick_1hz    (tick_1hz),
    .mins        (mins),
    .secs        (secs),
    .magnetron   (magnetron),
    .alarm       (alarm),
    .state       (state)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case the run never reaches its summary.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void add(bit key, logic [3:0] d, bit st, bit sp, bit cn, bit tk,
                              bit door, state_t es, logic [7:0] em, logic [7:0] esec);
    vec_t v;
    v.key = key; v.d = d; v.start = st; v.stop = sp; v.cancel = cn;
    v.tick = tk; v.door = door; v.es = es; v.em = em; v.esec = esec;
    vecs.push_back(v);
  endfunction

  function automatic void key_row(logic [3:0] d, state_t es, logic [7:0] em, logic [7:0] esec);
    add(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, es, em, esec);
  endfunction

  function automatic void act(bit st, bit sp, bit cn, bit tk, bit door,
                              state_t es, logic [7:0] em, logic [7:0] esec);
    add(1'b0, 4'd0, st, sp, cn, tk, door, es, em, esec);
  endfunction

  task automatic compareField(input string tag, input string field,
                              input logic [7:0] got, input logic [7:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s %s: got %h, expected %h", tag, field, got, want);
    end
  endtask

  // Output flags follow from the state: heating only in COOK, beeping only in DONE,
  // encoder disabled outside IDLE/ENTRY.
  task automatic checkOutput(input string tag, input state_t es,
                             input logic [7:0] em, input logic [7:0] esec);
    logic exp_mag, exp_alarm, exp_enbn;
    exp_mag   = (es == COOK);
    exp_alarm = (es == DONE);
    exp_enbn  = !((es == IDLE) || (es == ENTRY));
    compareField(tag, "state",     {5'd0, state},     {5'd0, 3'(es)});
    compareField(tag, "mins",      mins,              em);
    compareField(tag, "secs",      secs,              esec);
    compareField(tag, "magnetron", {7'd0, magnetron}, {7'd0, exp_mag});
    compareField(tag, "alarm",     {7'd0, alarm},     {7'd0, exp_alarm});
    compareField(tag, "enbn",      {7'd0, enbn},      {7'd0, exp_enbn});
  endtask

  // Drive one action for a cycle, then release the buttons for a cycle.
  task automatic applyStimulus(input vec_t v);
    D           = v.d;
    loadn       = ~v.key;
    startn      = ~v.start;
    stopn       = ~v.stop;
    canceln     = ~v.cancel;
    tick_1hz    = v.tick;
    door_closed = v.door;
    @(negedge clk);
    loadn    = 1'b1;
    startn   = 1'b1;
    stopn    = 1'b1;
    canceln  = 1'b1;
    tick_1hz = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    rstn = 1'b0; D = 4'd0; loadn = 1'b1; startn = 1'b1; stopn = 1'b1;
    canceln = 1'b1; door_closed = 1'b1; tick_1hz = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset", IDLE, 8'h00, 8'h00);
    rstn = 1'b1;
    @(negedge clk);

    // Entry of 1,3,0, invalid digit, cancel, zero/door-open starts.
    key_row(4'd1, ENTRY, 8'h00, 8'h01);
    key_row(4'd3, ENTRY, 8'h00, 8'h13);
    key_row(4'd0, ENTRY, 8'h01, 8'h30);
    key_row(4'hA, ENTRY, 8'h01, 8'h30);
    act(0, 0, 1, 0, 1, IDLE,  8'h00, 8'h00);
    key_row(4'd0, ENTRY, 8'h00, 8'h00);
    act(1, 0, 0, 0, 1, ENTRY, 8'h00, 8'h00);
    key_row(4'd3, ENTRY, 8'h00, 8'h03);
    key_row(4'd0, ENTRY, 8'h00, 8'h30);
    act(1, 0, 0, 0, 0, ENTRY, 8'h00, 8'h30);
    act(1, 0, 0, 0, 1, COOK,  8'h00, 8'h30);
    act(0, 0, 0, 1, 1, COOK,  8'h00, 8'h29);
    act(0, 1, 0, 0, 1, PAUSE, 8'h00, 8'h29);
    act(0, 0, 0, 1, 1, PAUSE, 8'h00, 8'h29);
    act(1, 0, 0, 0, 1, COOK,  8'h00, 8'h29);
    act(0, 1, 0, 1, 1, PAUSE, 8'h00, 8'h29);
    act(0, 1, 0, 0, 1, IDLE,  8'h00, 8'h00);
    // 0100 -> 0059.
    key_row(4'd1, ENTRY, 8'h00, 8'h01);
    key_row(4'd0, ENTRY, 8'h00, 8'h10);
    key_row(4'd0, ENTRY, 8'h01, 8'h00);
    act(1, 0, 0, 0, 1, COOK,  8'h01, 8'h00);
    act(0, 0, 0, 1, 1, COOK,  8'h00, 8'h59);
    act(0, 0, 1, 0, 1, IDLE,  8'h00, 8'h00);
    // 0090 -> 0089, then tick with cancel clears.
    key_row(4'd9, ENTRY, 8'h00, 8'h09);
    key_row(4'd0, ENTRY, 8'h00, 8'h90);
    act(1, 0, 0, 0, 1, COOK,  8'h00, 8'h90);
    act(0, 0, 0, 1, 1, COOK,  8'h00, 8'h89);
    act(0, 0, 1, 1, 1, IDLE,  8'h00, 8'h00);
    // 0010 with cancel, stop and tick together.
    key_row(4'd1, ENTRY, 8'h00, 8'h01);
    key_row(4'd0, ENTRY, 8'h00, 8'h10);
    act(1, 0, 0, 0, 1, COOK,  8'h00, 8'h10);
    act(0, 1, 1, 1, 1, IDLE,  8'h00, 8'h00);
    // 0002 full cook, five alarm ticks.
    key_row(4'd2, ENTRY, 8'h00, 8'h02);
    act(1, 0, 0, 0, 1, COOK,  8'h00, 8'h02);
    act(0, 0, 0, 1, 1, COOK,  8'h00, 8'h01);
    act(0, 0, 0, 1, 1, DONE,  8'h00, 8'h00);
    for (int i = 0; i < 4; i++) act(0, 0, 0, 1, 1, DONE, 8'h00, 8'h00);
    act(0, 0, 0, 1, 1, IDLE,  8'h00, 8'h00);
    // 0045 door open pause and resume.
    key_row(4'd4, ENTRY, 8'h00, 8'h04);
    key_row(4'd5, ENTRY, 8'h00, 8'h45);
    act(1, 0, 0, 0, 1, COOK,  8'h00, 8'h45);
    act(0, 0, 0, 0, 0, PAUSE, 8'h00, 8'h45);
    act(0, 0, 0, 1, 0, PAUSE, 8'h00, 8'h45);
    act(1, 0, 0, 0, 1, COOK,  8'h00, 8'h45);
    act(0, 0, 0, 1, 1, COOK,  8'h00, 8'h44);
    act(0, 1, 0, 0, 1, PAUSE, 8'h00, 8'h44);
    act(0, 0, 1, 0, 1, IDLE,  8'h00, 8'h00);
    // Final tick with door opening pauses at 0001; DONE exit on door, counter clears.
    key_row(4'd2, ENTRY, 8'h00, 8'h02);
    act(1, 0, 0, 0, 1, COOK,  8'h00, 8'h02);
    act(0, 0, 0, 1, 1, COOK,  8'h00, 8'h01);
    act(0, 0, 0, 1, 0, PAUSE, 8'h00, 8'h01);
    act(1, 0, 0, 0, 1, COOK,  8'h00, 8'h01);
    act(0, 0, 0, 1, 1, DONE,  8'h00, 8'h00);
    act(0, 0, 0, 1, 1, DONE,  8'h00, 8'h00);
    act(0, 0, 0, 0, 0, IDLE,  8'h00, 8'h00);
    key_row(4'd1, ENTRY, 8'h00, 8'h01);
    act(1, 0, 0, 0, 1, COOK,  8'h00, 8'h01);
    act(0, 0, 0, 1, 1, DONE,  8'h00, 8'h00);
    for (int i = 0; i < 4; i++) act(0, 0, 0, 1, 1, DONE, 8'h00, 8'h00);
    act(0, 0, 0, 1, 1, IDLE,  8'h00, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].es, vecs[i].em, vecs[i].esec);
    end

    // Holding loadn low for 50 cycles enters exactly one digit.
    D = 4'd7;
    loadn = 1'b0;
    repeat (50) @(negedge clk);
    loadn = 1'b1;
    @(negedge clk);
    checkOutput("hold_key", ENTRY, 8'h00, 8'h07);

    v = '{key: 1'b0, d: 4'd0, start: 1'b1, stop: 1'b0, cancel: 1'b0, tick: 1'b0,
          door: 1'b1, es: COOK, em: 8'h00, esec: 8'h07};
    applyStimulus(v);
    checkOutput("cook7", COOK, 8'h00, 8'h07);

    // Reset asserted between clock edges drops everything immediately.
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_reset", IDLE, 8'h00, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("post_reset", IDLE, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/microwave_ctrl.md
Name: microwave_ctrl

Overview:
- Top-level sequencer of the microwave oven.
- Consumes keypad digits from the keypad encoder (D/loadn) and assembles a 4-digit BCD cook time (MM:SS).
- Runs the start/stop/cancel/door state machine, counts the time down on a 1 Hz strobe, and drives the magnetron and the end-of-cook alarm.
- Gates the encoder through its active-low enable.

Parameters:
- ALARM_TICKS, 5: number of tick_1hz strobes the alarm stays asserted in DONE.
- TICK_EN_IN_PAUSE, 0: reserved; must be 0, meaning time is frozen while paused.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- D  in  4  digit from encoder; valid while loadn low
- loadn  in  1  encoder key-valid, active low, level
- enbn  out  1  encoder enable, active low
- startn  in  1  start button, debounced, active low, level
- stopn  in  1  stop/pause button, debounced, active low, level
- canceln  in  1  cancel/clear button, debounced, active low, level
- door_closed  in  1  1 = door closed
- tick_1hz  in  1  one-clk strobe per second, from the mod100 divider chain
- mins  out  8  BCD minutes {tens, units}
- secs  out  8  BCD seconds {tens, units}
- magnetron  out  1  1 = heating
- alarm  out  1  1 = end-of-cook beeper
- state  out  3  current FSM state, for display/debug

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, mins=secs=8'h00, magnetron=0, alarm=0, enbn=0, all edge-detect registers=1 (released), alarm counter=0.
- Edge detection: loadn, startn, stopn and canceln are each registered once. An event is that registered value high AND the current input low (falling edge). Holding a button produces exactly one event.
- Event priority within one cycle: cancel > stop > door open > start > key.
- Key event: digit = D.
  - If D > 9: ignore the event.
  - Otherwise shift left one digit: {mins,secs} <= {mins[3:0], secs, D}. The top digit is dropped.
- States (encoded in the shared header):
  - IDLE:
    - enbn=0.
    - key event -> shift digit, go to ENTRY.
    - start/stop/cancel -> stay; time held at 0000.
  - ENTRY:
    - enbn=0.
    - key event -> shift.
    - cancel -> time=0000, go to IDLE.
    - start with door_closed=1 and time != 0000 -> COOK. Otherwise start is ignored.
  - COOK:
    - enbn=1, magnetron=1 (registered; goes high the cycle the state becomes COOK).
    - On tick_1hz, decrement the time one second.
    - cancel -> time=0000, IDLE.
    - stop or door_closed=0 -> PAUSE; time retained.
    - A decrement that produces 0000 -> DONE. magnetron falls in the same cycle DONE is entered.
  - PAUSE:
    - enbn=1, magnetron=0, ticks ignored.
    - start with door_closed=1 -> COOK.
    - stop or cancel -> time=0000, IDLE.
  - DONE:
    - alarm=1, enbn=1.
    - The counter increments on each tick.
    - When the counter reaches ALARM_TICKS -> IDLE, alarm=0.
    - Any button event or door_closed=0 -> IDLE immediately.
    - The counter clears on exit.
- Decrement rules (BCD, per digit, no binary arithmetic):
  - secs units: 0 wraps to 9 with borrow.
  - secs tens: 0 with borrow wraps to 5 with borrow into mins.
  - mins borrow: units 0 wraps to 9, borrow into tens.
  - Time 0000 never decrements and never wraps to 9959.
  - Seconds entered above 59 (e.g. 0090) are legal and count down as entered: 0090 -> 0089 ... -> 0000.
- Simultaneous tick and stop in COOK: stop wins; the tick is discarded and time is unchanged.
- Simultaneous tick and cancel: the time clears.
- Simultaneous tick taking time to 0000 and the door opening: PAUSE wins and time holds at 0001.
- Reset during COOK: magnetron drops asynchronously with rstn.

Decomposition:
- Shared header microondas_defs.vh:
  - state codes: IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4
  - BCD constants: BCD_MAX_UNIT=9, BCD_MAX_SEC_TENS=5
- Sub-module bcd_countdown:
  - combinational {mins,secs} -> decremented value plus zero flag
  - instantiated once inside microwave_ctrl
- The FSM, edge detectors, digit shift register and alarm counter live in microwave_ctrl.

Test Plan:
- Reset, then keys 1,3,0 (one loadn falling edge each, D held) -> after the third event mins=8'h01, secs=8'h30, state=ENTRY, enbn=0. Holding loadn low for 50 clk adds no digits.
- Time 0002, door closed, start -> magnetron=1 the next cycle. After 2 ticks: secs=00, state=DONE, magnetron=0, alarm=1. After 5 more ticks: alarm=0, state=IDLE.
- Time 0100, COOK, one tick -> mins=00, secs=59. Time 0090, one tick -> secs=89.
- COOK at 0045: drop door_closed -> PAUSE, magnetron=0. Ticks leave time at 0045. Close the door and press start -> COOK resumes from 0045.
- ENTRY at 0000 (digit 0 entered) with start -> stays ENTRY. Time 0030 with the door open and start -> stays ENTRY. D=4'hA key -> ignored.
- Same-cycle cancel, stop and tick in COOK at 0010 -> IDLE, time 0000. Assert rstn low mid-COOK -> magnetron=0 immediately and all outputs at reset values.
